// File: rtl/ov_capture_writer.sv
// rtl/ov_capture_writer.sv - OV7670 RGB565 byte stream to RGB444 frame-buffer write port
// Skips warm-up frames after enable, packs byte pairs into pixels and bounds writes to FB depth.
module ov_capture_writer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = 19,
    parameter int SKIP_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [11:0]       dina,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              overflow
);

    localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);
    // pix_addr is one bit wider so it can sit at FB depth once the buffer is full
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SYNC    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]        state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [ADDR_W:0]   pix_addr;
    logic              phase;
    logic [6:0]        b1;
    logic              v_q, v_q_d, h_q;
    logic [7:0]        d_q;
    logic              vs_rise;

    assign vs_rise = v_q & ~v_q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= 1'b0;
            v_q_d      <= 1'b0;
            h_q        <= 1'b0;
            d_q        <= '0;
            state      <= S_IDLE;
            skip_cnt   <= '0;
            pix_addr   <= '0;
            phase      <= 1'b0;
            b1         <= '0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            overflow   <= 1'b0;
        end else begin
            v_q        <= cam_vsync;
            v_q_d      <= v_q;
            h_q        <= cam_href;
            d_q        <= cam_data;
            wea        <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state    <= S_SYNC;
                        skip_cnt <= '0;
                    end
                end
                S_SYNC: begin
                    if (vs_rise) begin
                        if (skip_cnt < SKIP_W'(SKIP_FRAMES)) begin
                            skip_cnt <= skip_cnt + SKIP_W'(1);
                        end else begin
                            state    <= S_CAPTURE;
                            pix_addr <= '0;
                            phase    <= 1'b0;
                            overflow <= 1'b0;
                        end
                    end
                end
                S_CAPTURE: begin
                    // vsync takes priority over any byte arriving on the same cycle
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        phase      <= 1'b0;
                        if (enable) begin
                            pix_addr <= '0;
                            overflow <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (h_q) begin
                        if (!phase) begin
                            b1    <= {d_q[7:4], d_q[2:0]};
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (pix_addr < DEPTH) begin
                                wea      <= 1'b1;
                                addra    <= pix_addr[ADDR_W-1:0];
                                dina     <= {b1[6:3], b1[2:0], d_q[7], d_q[4:1]};
                                pix_addr <= pix_addr + (ADDR_W+1)'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end else begin
                        phase <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov_capture_writer.sv
// tb/tb_ov_capture_writer.sv - self-checking bench for ov_capture_writer
// Per-cycle comparison against a frame/pixel level model plus literal pins.
module tb_ov_capture_writer;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int AW    = 3;
    localparam int SKIP  = 1;
    localparam int DEPTH = H * V;
    localparam int NCYC  = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          wea;
    logic [AW-1:0] addra;
    logic [11:0]   dina;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic          overflow;

    ov_capture_writer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SKIP_FRAMES(SKIP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .wea(wea), .addra(addra), .dina(dina),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    bit e_wea[NCYC];
    int e_addr[NCYC];
    int e_dina[NCYC];
    bit e_fd[NCYC];
    int e_cnt[NCYC];
    bit e_ovf[NCYC];

    // Model: 0 = disabled, 1 = armed (counting warm-up vsyncs), 2 = capturing
    int m_mode = 0, m_skipped = 0, m_pix = 0, m_first = 0, m_addr = 0, m_data = 0, m_cnt = 0;
    bit m_have = 0, m_ovf = 0, prev_vs = 0;

    int wl_addr[$];
    int wl_data[$];
    int wl_cyc[$];
    int fd_total = 0;
    int bq[$];

    function automatic int rgb444(input int p565);
        int r5, g6, b5;
        r5 = (p565 >> 11) & 31;
        g6 = (p565 >> 5) & 63;
        b5 = p565 & 31;
        return ((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1);
    endfunction

    task automatic clear_exp(input int c);
        if (c < NCYC) begin
            e_wea[c] = 0; e_addr[c] = 0; e_dina[c] = 0;
            e_fd[c] = 0; e_cnt[c] = 0; e_ovf[c] = 0;
        end
    endtask

    task automatic model_step(input bit en, input bit vs, input bit hr, input int d);
        int c;
        bit w, fd, rise;
        c = cyc + 2;
        w = 0;
        fd = 0;
        if (!rst_n) begin
            m_mode = 0; m_skipped = 0; m_pix = 0; m_first = 0; m_addr = 0;
            m_data = 0; m_cnt = 0; m_have = 0; m_ovf = 0; prev_vs = 0;
            for (int i = 0; i < 3; i++) clear_exp(cyc + i);
            return;
        end
        rise = vs && !prev_vs;
        prev_vs = vs;
        if (m_mode == 0) begin
            if (en) begin m_mode = 1; m_skipped = 0; end
        end else if (rise) begin
            if (m_mode == 1) begin
                if (m_skipped < SKIP) m_skipped++;
                else begin m_mode = 2; m_pix = 0; m_ovf = 0; end
            end else begin
                fd = 1;
                m_cnt = (m_cnt + 1) % 256;
                if (en) begin m_pix = 0; m_ovf = 0; end
                else m_mode = 0;
            end
            m_have = 0;
        end else if (m_mode == 2 && hr) begin
            if (!m_have) begin
                m_first = d;
                m_have = 1;
            end else begin
                m_have = 0;
                if (m_pix < DEPTH) begin
                    w = 1;
                    m_addr = m_pix;
                    m_data = rgb444(m_first * 256 + d);
                    m_pix++;
                end else begin
                    m_ovf = 1;
                end
            end
        end else begin
            m_have = 0;
        end
        if (c < NCYC) begin
            e_wea[c] = w; e_addr[c] = m_addr; e_dina[c] = m_data;
            e_fd[c] = fd; e_cnt[c] = m_cnt; e_ovf[c] = m_ovf;
        end
    endtask

    task automatic tick(input bit vs, input bit hr, input int d);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = 8'(d);
        model_step(enable, vs, hr, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 3; i++) tick(1, 0, 0);
        idle(4);
    endtask

    task automatic send_bq();
        foreach (bq[i]) tick(0, 1, bq[i]);
        idle(3);
    endtask

    task automatic pix_line(input int n, input int seed);
        bq.delete();
        for (int i = 0; i < n; i++) begin
            bq.push_back((seed + i * 37) & 255);
            bq.push_back((seed * 3 + i * 91) & 255);
        end
        send_bq();
    endtask

    task automatic clear_log();
        wl_addr.delete();
        wl_data.delete();
        wl_cyc.delete();
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            checks++;
            if (wea !== e_wea[cyc] || addra !== AW'(e_addr[cyc]) || dina !== 12'(e_dina[cyc]) ||
                frame_done !== e_fd[cyc] || frame_cnt !== 8'(e_cnt[cyc]) || overflow !== e_ovf[cyc]) begin
                errors++;
                $display("FAIL cycle%0d got wea=%0b addra=%0d dina=%h fd=%0b cnt=%0d ovf=%0b required wea=%0b addra=%0d dina=%h fd=%0b cnt=%0d ovf=%0b",
                         cyc, wea, addra, dina, frame_done, frame_cnt, overflow,
                         e_wea[cyc], e_addr[cyc], 12'(e_dina[cyc]), e_fd[cyc], e_cnt[cyc], e_ovf[cyc]);
            end
        end
        if (wea === 1'b1) begin
            wl_addr.push_back(int'(addra));
            wl_data.push_back(int'(dina));
            wl_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) fd_total++;
    end

    initial begin
        int t2;
        check("model_red", rgb444(16'hF800), 12'hF00);
        check("model_green", rgb444(16'h07E0), 12'h0F0);
        check("model_mix", rgb444(16'h1234), 12'h14A);

        rst_n = 1'b0;
        idle(4);
        check("reset_dina", int'(dina), 0);
        check("reset_cnt", int'(frame_cnt), 0);
        rst_n = 1'b1;
        enable = 1'b1;
        idle(4);

        // warm-up frame is discarded
        clear_log();
        vsync_pulse();
        bq = '{'hF8, 'h1F};
        send_bq();
        check("skip_no_write", wl_addr.size(), 0);

        // first captured frame: primaries and latency
        vsync_pulse();
        clear_log();
        tick(0, 1, 'hF8);
        t2 = cyc;
        tick(0, 1, 'h00);
        tick(0, 1, 'h07);
        tick(0, 1, 'hE0);
        tick(0, 1, 'h00);
        tick(0, 1, 'h1F);
        idle(3);
        check("t2_writes", wl_addr.size(), 3);
        if (wl_addr.size() == 3) begin
            check("t2_addr0", wl_addr[0], 0);
            check("t2_dina0", wl_data[0], 12'hF00);
            check("t2_addr1", wl_addr[1], 1);
            check("t2_dina1", wl_data[1], 12'h0F0);
            check("t2_addr2", wl_addr[2], 2);
            check("t2_dina2", wl_data[2], 12'h00F);
            check("t2_latency", wl_cyc[0] - t2, 2);
        end

        // close it, then a full frame
        vsync_pulse();
        check("t3_cnt1", int'(frame_cnt), 1);
        check("t3_fd1", fd_total, 1);
        clear_log();
        pix_line(H, 17);
        pix_line(H, 99);
        vsync_pulse();
        check("t3_writes", wl_addr.size(), 8);
        if (wl_addr.size() == 8) begin
            check("t3_first_addr", wl_addr[0], 0);
            check("t3_last_addr", wl_addr[7], 7);
        end
        check("t3_cnt2", int'(frame_cnt), 2);
        check("t3_fd2", fd_total, 2);

        // oversize frame
        clear_log();
        pix_line(10, 5);
        check("t4_writes", wl_addr.size(), 8);
        check("t4_ovf_set", int'(overflow), 1);
        vsync_pulse();
        check("t4_ovf_clr", int'(overflow), 0);
        check("t4_cnt3", int'(frame_cnt), 3);

        // odd trailing byte, then vsync landing on a byte
        clear_log();
        bq = '{'h12, 'h34, 'h56};
        send_bq();
        bq = '{'hF8, 'h00};
        send_bq();
        check("t5_writes", wl_addr.size(), 2);
        if (wl_addr.size() == 2) begin
            check("t5_dina0", wl_data[0], 12'h14A);
            check("t5_addr1", wl_addr[1], 1);
            check("t5_dina1", wl_data[1], 12'hF00);
        end
        clear_log();
        tick(0, 1, 'hAB);
        tick(1, 1, 'hCD);
        tick(1, 0, 0);
        tick(1, 0, 0);
        idle(3);
        check("t5_vs_nowrite", wl_addr.size(), 0);
        bq = '{'h07, 'hE0};
        send_bq();
        check("t5_realign_n", wl_addr.size(), 1);
        if (wl_addr.size() == 1) begin
            check("t5_realign_addr", wl_addr[0], 0);
            check("t5_realign_dina", wl_data[0], 12'h0F0);
        end
        check("t5_cnt4", int'(frame_cnt), 4);

        // enable dropped mid-frame: frame completes, then idle
        pix_line(2, 40);
        enable = 1'b0;
        pix_line(1, 41);
        vsync_pulse();
        check("t7_cnt5", int'(frame_cnt), 5);
        clear_log();
        vsync_pulse();
        pix_line(2, 50);
        check("t7_idle_nowrite", wl_addr.size(), 0);
        enable = 1'b1;
        idle(3);
        vsync_pulse();
        vsync_pulse();
        clear_log();
        bq = '{'hF8, 'h1F};
        send_bq();
        check("t7_resume_n", wl_addr.size(), 1);
        if (wl_addr.size() == 1) check("t7_resume_dina", wl_data[0], 12'hF0F);

        // asynchronous reset mid-line
        tick(0, 1, 'h11);
        tick(0, 1, 'h22);
        tick(0, 1, 'h33);
        rst_n = 1'b0;
        #1;
        check("t6_wea", int'(wea), 0);
        check("t6_addra", int'(addra), 0);
        check("t6_dina", int'(dina), 0);
        check("t6_cnt", int'(frame_cnt), 0);
        idle(3);
        rst_n = 1'b1;
        idle(3);
        clear_log();
        vsync_pulse();
        bq = '{'hF8, 'h1F};
        send_bq();
        check("t6_skip_nowrite", wl_addr.size(), 0);
        vsync_pulse();
        bq = '{'h00, 'h1F};
        send_bq();
        check("t6_writes", wl_addr.size(), 1);
        if (wl_addr.size() == 1) begin
            check("t6_addr0", wl_addr[0], 0);
            check("t6_dina0", wl_data[0], 12'h00F);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
